// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared FSM encoding and mode constants for stream_mux_rr.
package stream_mux_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority search from ptr over req, gated by en.
//   req_i[N_CH]        request vector
//   ptr_i[SELW]        highest-priority channel
//   en_i               grant enable
//   grant_o[N_CH]      one-hot grant
//   grant_idx_o[SELW]  index of granted channel
//   any_o              a grant exists
module rr_arbiter #(
  parameter int N_CH = 4,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [SELW-1:0] ptr_i,
  input  logic            en_i,
  output logic [N_CH-1:0] grant_o,
  output logic [SELW-1:0] grant_idx_o,
  output logic            any_o
);
  always_comb begin
    int c;
    c = 0;
    grant_o = '0;
    grant_idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      c = (int'(ptr_i) + k) % N_CH;
      if (en_i && !any_o && req_i[c]) begin
        any_o = 1'b1;
        grant_o[c] = 1'b1;
        grant_idx_o = SELW'(c);
      end
    end
  end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel registered stream mux, fixed-select or round-robin, with packet lock.
//   clk_i, rst_ni          clock, synchronous active-low reset
//   in_data_i/valid_i/last_i, in_ready_o   per-channel input streams
//   mode_i (0 sel, 1 rr), sel_i            arbitration control
//   out_data_o/last_o/ch_o/valid_o, out_ready_i   registered output stream
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW = 8,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_CH*DW-1:0] in_data_i,
  input  logic [N_CH-1:0]    in_valid_i,
  input  logic [N_CH-1:0]    in_last_i,
  output logic [N_CH-1:0]    in_ready_o,
  input  logic               mode_i,
  input  logic [SELW-1:0]    sel_i,
  output logic [DW-1:0]      out_data_o,
  output logic               out_last_o,
  output logic [SELW-1:0]    out_ch_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);
  state_e state_q, state_d;
  logic [SELW-1:0] lock_q, lock_d, rr_q, rr_d, ch_q, ch_d, arb_ptr, gidx;
  logic [DW-1:0] data_q, data_d;
  logic last_q, last_d, valid_q, valid_d, load_en, fire, beat_last;
  logic [N_CH-1:0] req, sel_oh, lock_oh;
  assign load_en = !valid_q || out_ready_i;
  // out-of-range sel shifts the one bit out, leaving no request
  assign sel_oh = N_CH'(1) << sel_i;
  assign lock_oh = N_CH'(1) << lock_q;
  assign arb_ptr = (state_q == LOCKED) ? lock_q : (mode_i == MODE_RR) ? rr_q : sel_i;
  assign req = in_valid_i & ((state_q == LOCKED) ? lock_oh : (mode_i == MODE_RR) ? '1 : sel_oh);
  // gating with rst_ni keeps every in_ready low during the reset cycle
  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req_i(req),
    .ptr_i(arb_ptr),
    .en_i(load_en && rst_ni),
    .grant_o(in_ready_o),
    .grant_idx_o(gidx),
    .any_o(fire)
  );
  assign beat_last = in_last_i[gidx];
  always_comb begin
    state_d = fire ? (beat_last ? IDLE : LOCKED) : state_q;
    lock_d = (fire && !beat_last) ? gidx : lock_q;
    // pointer advances only on packet end in rr mode, including a packet finishing under lock
    rr_d = (fire && beat_last && mode_i == MODE_RR) ?
           ((gidx == SELW'(N_CH - 1)) ? '0 : gidx + 1'b1) : rr_q;
    valid_d = load_en ? fire : valid_q;
    data_d = fire ? in_data_i[gidx*DW +: DW] : data_q;
    last_d = fire ? beat_last : last_q;
    ch_d = fire ? gidx : ch_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lock_q <= '0;
      rr_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      ch_q <= '0;
    end else begin
      state_q <= state_d;
      lock_q <= lock_d;
      rr_q <= rr_d;
      valid_q <= valid_d;
      data_q <= data_d;
      last_q <= last_d;
      ch_q <= ch_d;
    end
  end
  assign out_data_o = data_q;
  assign out_last_o = last_q;
  assign out_ch_o = ch_q;
  assign out_valid_o = valid_q;
endmodule
